// File: rtl/vproc_bus_mem.sv
// vproc_bus_mem: word-addressed memory target for the VProc bus.
// Decodes a 2^MEM_WIDTH-word window at BASE_ADDR, acknowledges each access
// with a one-cycle WRAck/RDAck pulse after a programmable number of wait
// states, and tracks burst framing. An unselected instance drives zeros, so
// several instances can be ORed onto one VProc bus.
//
// Ports:
//   Clk, Reset        clock, asynchronous active-high reset
//   Addr, WE, RD      word address and request strobes from VProc
//   WrData            write data (VProc DataOut)
//   Burst             burst length, valid with BurstFirst
//   BurstFirst/Last   burst framing markers
//   RdData            read data (VProc DataIn), zero unless RDAck
//   WRAck, RDAck      one-cycle acknowledge pulses
//   ProtErr           sticky: WE and RD seen together
//   BurstErr          sticky: burst framing mismatch
module vproc_bus_mem #(
  parameter int unsigned MEM_WIDTH   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned BURST_WAIT  = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic        RD,
  input  logic [31:0] WrData,
  input  logic [11:0] Burst,
  input  logic        BurstFirst,
  input  logic        BurstLast,
  output logic [31:0] RdData,
  output logic        WRAck,
  output logic        RDAck,
  output logic        ProtErr,
  output logic        BurstErr
);

  localparam int unsigned DEPTH  = 1 << MEM_WIDTH;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BEAT_W = 12;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  logic [31:0]          mem [DEPTH];
  state_t               state;
  logic [CNT_W-1:0]     wait_cnt;
  logic [BEAT_W-1:0]    beat_cnt;
  logic                 cap_we;
  logic [MEM_WIDTH-1:0] cap_idx;
  logic [31:0]          cap_data;

  logic                 sel_c;
  logic                 capture_c;
  logic [CNT_W-1:0]     load_wait_c;
  logic                 go_ack_c;
  logic                 ack_we_c;
  logic [MEM_WIDTH-1:0] ack_idx_c;
  logic [31:0]          ack_data_c;
  logic [BEAT_W-1:0]    beat_eff_c;
  logic [BEAT_W-1:0]    beat_next_c;
  logic                 burst_err_c;

  // Decode, wait-value selection and the edge that enters ACK.
  always_comb begin
    sel_c       = (Addr[31:MEM_WIDTH] == BASE_ADDR[31:MEM_WIDTH]) && (WE || RD);
    capture_c   = (state == ST_IDLE) && sel_c;
    // A beat inside an open burst (not a new first beat) uses the burst wait.
    load_wait_c = ((beat_cnt != '0) && !BurstFirst) ? CNT_W'(BURST_WAIT)
                                                    : CNT_W'(WAIT_STATES);
    go_ack_c    = !Reset &&
                  ((capture_c && (load_wait_c == '0)) ||
                   ((state == ST_WAIT) && (wait_cnt == CNT_W'(1))));
    // A zero-wait access acks on its capture edge, so bypass the capture regs.
    ack_we_c    = (state == ST_IDLE) ? WE : cap_we;
    ack_idx_c   = (state == ST_IDLE) ? Addr[MEM_WIDTH-1:0] : cap_idx;
    ack_data_c  = (state == ST_IDLE) ? WrData : cap_data;
  end

  // Burst framing: next beat count and error detection at capture.
  always_comb begin
    beat_eff_c  = BurstFirst ? Burst : beat_cnt;
    burst_err_c = (BurstFirst && ((beat_cnt != '0) || (Burst == '0))) ||
                  (BurstLast && (beat_eff_c != BEAT_W'(1)));
    beat_next_c = beat_cnt;
    if (BurstFirst) begin
      beat_next_c = Burst;
    end else if (BurstLast && (beat_cnt != BEAT_W'(1))) begin
      // A premature last marker closes the burst.
      beat_next_c = '0;
    end
  end

  // Control FSM with registered acks, read data and sticky errors.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      beat_cnt <= '0;
      cap_we   <= 1'b0;
      cap_idx  <= '0;
      cap_data <= '0;
      RdData   <= '0;
      WRAck    <= 1'b0;
      RDAck    <= 1'b0;
      ProtErr  <= 1'b0;
      BurstErr <= 1'b0;
    end else begin
      WRAck  <= 1'b0;
      RDAck  <= 1'b0;
      RdData <= '0;
      case (state)
        ST_IDLE: begin
          if (capture_c) begin
            cap_we   <= WE;
            cap_idx  <= Addr[MEM_WIDTH-1:0];
            cap_data <= WrData;
            wait_cnt <= load_wait_c;
            beat_cnt <= beat_next_c;
            if (WE && RD) ProtErr <= 1'b1;
            if (burst_err_c) BurstErr <= 1'b1;
            state <= (load_wait_c == '0) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - CNT_W'(1);
          if (wait_cnt == CNT_W'(1)) state <= ST_ACK;
        end
        ST_ACK: begin
          state <= ST_IDLE;
          if (beat_cnt != '0) beat_cnt <= beat_cnt - BEAT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
      if (go_ack_c) begin
        WRAck <= ack_we_c;
        RDAck <= !ack_we_c;
        if (!ack_we_c) RdData <= mem[ack_idx_c];
      end
    end
  end

  // Single-port RAM write; not reset.
  always_ff @(posedge Clk) begin
    if (go_ack_c && ack_we_c) mem[ack_idx_c] <= ack_data_c;
  end

endmodule

// File: doc/vproc_bus_mem.md
# vproc_bus_mem

Word-addressed memory target for the VProc bus. It sits directly downstream of a VProc instance and consumes the `Addr`/`WE`/`RD`/`DataOut` accesses it issues. It returns `DataIn` with single-cycle `WRAck`/`RDAck` pulses after a programmable number of wait states, and it tracks burst framing. Several instances can be ORed onto one VProc bus, because an unselected instance drives zeros.

## Interface

Parameters:
- `MEM_WIDTH`, default 10: log2 of the memory depth in 32-bit words.
- `BASE_ADDR`, default 32'h0: base word address. It must be aligned to 2^`MEM_WIDTH`.
- `WAIT_STATES`, default 1: extra cycles before the ack on a single access or on the first beat of a burst (0–255).
- `BURST_WAIT`, default 0: extra cycles before the ack on each non-first burst beat (0–255).

Ports:
- `Clk`  in  1: clock; all state changes on the rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `Addr`  in  32: word address from VProc.
- `WE`  in  1: write request.
- `RD`  in  1: read request.
- `WrData`  in  32: write data (VProc `DataOut`).
- `Burst`  in  12: burst length, valid while `BurstFirst`=1.
- `BurstFirst`  in  1: first beat of a burst.
- `BurstLast`  in  1: last beat of a burst.
- `RdData`  out  32: read data (VProc `DataIn`). It is 0 whenever `RDAck`=0.
- `WRAck`  out  1: write acknowledge, one-cycle pulse.
- `RDAck`  out  1: read acknowledge, one-cycle pulse.
- `ProtErr`  out  1: sticky flag for simultaneous `WE` and `RD`.
- `BurstErr`  out  1: sticky flag for a burst framing mismatch.

## Operation

- **Select:** `Sel` = (`Addr[31:MEM_WIDTH]` == `BASE_ADDR[31:MEM_WIDTH]`) and (`WE` or `RD`).
  - An unselected request is ignored: no ack, and no change to state or errors.
- **State machine:** IDLE, WAIT, ACK.
- **IDLE:** on an edge with `Sel`=1, capture direction, `Addr[MEM_WIDTH-1:0]` and `WrData`.
  - The wait counter loads `BURST_WAIT` if the access is a non-first burst beat (beat counter > 0), otherwise `WAIT_STATES`.
  - Counter = 0: go to ACK. Counter ≠ 0: go to WAIT.
- **WAIT:** decrement the counter each edge; go to ACK on the edge where it reaches 0.
  - Inputs are not re-sampled in WAIT. VProc holds them stable until acked.
- **Entering ACK (same edge):**
  - Write: store the captured data to `mem[idx]` and register `WRAck`=1.
  - Read: register `RdData`=`mem[idx]` and `RDAck`=1.
- **ACK:** lasts exactly one cycle. On the next edge, clear the acks and `RdData` to 0 and return to IDLE.
  - Back-to-back acks are never produced. VProc updates its outputs at the ack edge, so the new command is sampled from IDLE on the edge after.
- **WE and RD both high:** treat as a write and set `ProtErr`.
- **Burst tracking:**
  - On a selected access with `BurstFirst`=1, load the beat counter with `Burst`.
  - Decrement the counter on every acked beat while it is > 0.
  - Set `BurstErr` if:
    - `BurstLast`=1 is seen at capture while the beat counter ≠ 1; or
    - `BurstFirst`=1 arrives while the beat counter > 0; or
    - `Burst`=0 arrives with `BurstFirst`=1.
  - On `BurstErr`, reload the beat counter from the new `Burst` (or clear it to 0 if `Burst`=0) and carry on serving accesses.
  - Burst addresses come from `Addr` on each beat; no internal increment.
- **Errors:** `ProtErr` and `BurstErr` clear only on `Reset`.
- **Memory:** single port, `2^MEM_WIDTH` × 32, not reset. It must be synthesisable and inferable as RAM.

## Timing

- **Reset (async, immediate):**
  - State returns to IDLE; the wait counter and beat counter clear to 0.
  - `WRAck`=0, `RDAck`=0, `RdData`=0, `ProtErr`=0, `BurstErr`=0.
  - An access in progress is dropped: no ack and no memory write.
- **Latency:** a request is sampled at edge S; the ack is high in the cycle after edge S + W, where W is the loaded wait value. VProc observes the ack at edge S + W + 1.
- **Throughput:** (W + 2) cycles per access.
- **Write visibility:** a read that follows a write to the same index returns the new data.
- **Wrap:** only the low `MEM_WIDTH` bits of `Addr` index memory. No wrap logic is needed because select excludes out-of-range addresses.

## Test plan

- **Single write then read, `WAIT_STATES`=1:** write 32'hA5A5_0001 to `BASE_ADDR`+3, then read it back.
  - `WRAck` pulses one cycle, 2 edges after the request is sampled.
  - `RDAck` pulses with `RdData`=32'hA5A5_0001.
  - `RdData`=0 in all other cycles.
- **Wait sweep:** with `WAIT_STATES` = 0, 3, 255, the ack arrives at S+1, S+4, S+256 respectively, and exactly one pulse is produced per access.
- **4-beat write burst then read burst, `BURST_WAIT`=0:** write bursts with `Burst`=4, `BurstFirst` on beat 1 and `BurstLast` on beat 4.
  - Beat acks are spaced 3 cycles (first) then 2 cycles apart.
  - Read-back returns all 4 words; `BurstErr` stays 0.
- **Framing errors:** (a) `BurstLast` on beat 2 of a `Burst`=4 burst sets `BurstErr`; (b) a new `BurstFirst` mid-burst sets `BurstErr`.
  - In both cases every access is still acked and `BurstErr` stays 1 until `Reset`.
- **Select, protocol error and reset:**
  - An access to an address outside the window gets no ack, `RdData` stays 0 and nothing changes.
  - `WE`=`RD`=1 writes the data and sets `ProtErr`.
  - `Reset` asserted during WAIT clears all outputs immediately; memory is unchanged and no ack follows.
